// File: rtl/move_sequencer_pkg.sv
// Shared types, codes and board helpers for the 2048 move sequencer.
// Latency: none (declarations and pure functions only).
// Backpressure: none.
package move_sequencer_pkg;

  localparam int CELL_W  = 4;
  localparam int N_CELLS = 16;
  localparam int BOARD_W = CELL_W * N_CELLS;

  // Bit positions inside dir[3:0] = {up, down, left, right}
  localparam int DIR_UP    = 3;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_RIGHT = 0;

  typedef logic [CELL_W-1:0]  cell_t;
  typedef logic [BOARD_W-1:0] board_t;
  // One line in the order of motion: element 0 is the front cell
  typedef cell_t [3:0]        line_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LATCH   = 3'd1,
    ST_SLIDE   = 3'd2,
    ST_SPAWN   = 3'd3,
    ST_COMMIT  = 3'd4,
    ST_CHECK   = 3'd5,
    ST_RELEASE = 3'd6,
    ST_OVER    = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    END_PLAY = 2'b00,
    END_WIN  = 2'b01,
    END_LOSE = 2'b10
  } end_t;

  // Cell n (row-major, 0 = top-left) lives in the most significant nibble first
  function automatic cell_t cell_get(board_t b, int n);
    return b[BOARD_W-1-CELL_W*n -: CELL_W];
  endfunction

  function automatic board_t cell_set(board_t b, int n, cell_t v);
    board_t r;
    r = b;
    r[BOARD_W-1-CELL_W*n -: CELL_W] = v;
    return r;
  endfunction

  // Board index of position pos (0 = front) of the given line index for one-hot direction d
  function automatic int line_cell(logic [3:0] d, int line, int pos);
    int idx;
    if (d[DIR_RIGHT])     idx = line * 4 + (3 - pos);
    else if (d[DIR_UP])   idx = pos * 4 + line;
    else if (d[DIR_DOWN]) idx = (3 - pos) * 4 + line;
    else                  idx = line * 4 + pos;
    return idx;
  endfunction

  // Merged tile code; 15 is the largest representable code and stays put
  function automatic cell_t merge_code(cell_t c);
    return (c == 4'hF) ? c : c + 4'd1;
  endfunction

endpackage

// File: rtl/move_sequencer_if.sv
// Direction/board bundle between the key logic, the box registers and the move sequencer.
// Latency: wires only.
// Backpressure: none; load is a single-cycle enable the boxes must accept.
interface move_sequencer_if;
  logic [3:0]  dir;
  logic [63:0] board_in;
  logic [63:0] board_out;
  logic        load;
  logic        busy;
  logic [1:0]  endstatus;
  logic [2:0]  state;

  // master: key logic plus box registers; slave: the move sequencer
  modport master (output dir, board_in,
                  input  board_out, load, busy, endstatus, state);
  modport slave  (input  dir, board_in,
                  output board_out, load, busy, endstatus, state);
endinterface

// File: rtl/move_sequencer_line_merge.sv
// Slides one 4-cell line toward element 0 and merges equal neighbours front-to-back.
// Latency: combinational.
// Backpressure: none.
module move_sequencer_line_merge
  import move_sequencer_pkg::*;
(
  input  line_t line_in,
  output line_t line_out
);

  cell_t [4:0] cmp;   // compacted line; element 4 stays empty as a sentinel
  logic  [2:0] k;
  logic  [2:0] o;
  logic        skip;

  // Compact, then merge pairs; skip marks a tile already consumed by a merge
  always_comb begin
    cmp      = '0;
    k        = 3'd0;
    line_out = '0;
    o        = 3'd0;
    skip     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (line_in[i] != '0) begin
        cmp[k[1:0]] = line_in[i];
        k           = k + 3'd1;
      end
    end
    for (int j = 0; j < 4; j++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (cmp[j] != '0) begin
        if (cmp[j] == cmp[j+1]) begin
          line_out[o[1:0]] = merge_code(cmp[j]);
          skip             = 1'b1;
        end else begin
          line_out[o[1:0]] = cmp[j];
        end
        o = o + 3'd1;
      end
    end
  end

endmodule

// File: rtl/move_sequencer.sv
// Runs one 2048 move: latch board, slide 4 lines through a shared merger, spawn a tile, commit, check end.
// Latency: key accepted at edge T, load high in the cycle ending at edge T+7; a no-move never loads.
// Backpressure: none; a held key yields one move, the next needs dir to return to zero first.
module move_sequencer
  import move_sequencer_pkg::*;
#(
  parameter int          WIN_CODE  = 11,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
)
(
  input logic             clock,
  input logic             reset,
  move_sequencer_if.slave bus
);

  state_t      st;
  board_t      work;
  board_t      orig;
  logic [3:0]  dir_q;
  logic [1:0]  line_idx;
  logic [15:0] lfsr;
  board_t      board_out_q;
  logic        load_q;
  logic        busy_q;
  end_t        end_q;

  line_t       line_in;
  line_t       line_out;
  board_t      work_slid;
  board_t      work_spawn;
  logic [3:0]  cand;
  logic [3:0]  spawn_idx;
  logic        found;
  logic        any_win;
  logic        any_empty;
  logic        any_pair;
  end_t        end_next;
  logic        dir_onehot;

  assign dir_onehot    = (bus.dir != 4'd0) && ((bus.dir & (bus.dir - 4'd1)) == 4'd0);

  assign bus.board_out = board_out_q;
  assign bus.load      = load_q;
  assign bus.busy      = busy_q;
  assign bus.endstatus = end_q;
  assign bus.state     = st;

  move_sequencer_line_merge u_merge (
    .line_in  (line_in),
    .line_out (line_out)
  );

  // Gather the current line front-first in the latched direction of motion
  always_comb begin
    line_in = '0;
    for (int p = 0; p < 4; p++)
      line_in[p] = cell_get(work, line_cell(dir_q, int'(line_idx), p));
  end

  // Write the merged line back into the same cells it came from
  always_comb begin
    work_slid = work;
    for (int p = 0; p < 4; p++)
      work_slid = cell_set(work_slid, line_cell(dir_q, int'(line_idx), p), line_out[p]);
  end

  // First empty cell at or after the LFSR start index, wrapping 15 -> 0
  always_comb begin
    cand      = 4'd0;
    spawn_idx = 4'd0;
    found     = 1'b0;
    for (int k = 0; k < N_CELLS; k++) begin
      cand = lfsr[3:0] + 4'(k);
      if (!found && cell_get(work, int'(cand)) == '0) begin
        found     = 1'b1;
        spawn_idx = cand;
      end
    end
    work_spawn = cell_set(work, int'(spawn_idx), (lfsr[7:4] == 4'd0) ? 4'd2 : 4'd1);
  end

  // Win/lose evaluation of the committed board
  always_comb begin
    any_win   = 1'b0;
    any_empty = 1'b0;
    any_pair  = 1'b0;
    for (int n = 0; n < N_CELLS; n++) begin
      if (cell_get(work, n) == 4'(WIN_CODE)) any_win = 1'b1;
      if (cell_get(work, n) == '0)          any_empty = 1'b1;
      if ((n % 4) != 3 && cell_get(work, n) == cell_get(work, (n + 1) % N_CELLS))
        any_pair = 1'b1;
      if (n < 12 && cell_get(work, n) == cell_get(work, (n + 4) % N_CELLS))
        any_pair = 1'b1;
    end
    if (any_win)                    end_next = END_WIN;
    else if (!any_empty && !any_pair) end_next = END_LOSE;
    else                            end_next = END_PLAY;
  end

  // Move FSM with registered outputs; the LFSR free-runs every cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      st          <= ST_IDLE;
      work        <= '0;
      orig        <= '0;
      dir_q       <= '0;
      line_idx    <= '0;
      lfsr        <= LFSR_SEED;
      board_out_q <= '0;
      load_q      <= 1'b0;
      busy_q      <= 1'b0;
      end_q       <= END_PLAY;
    end else begin
      lfsr   <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      load_q <= 1'b0;
      unique case (st)
        ST_IDLE: begin
          // Direction is captured on acceptance, where it is known to be one-hot
          if (dir_onehot && end_q == END_PLAY) begin
            dir_q  <= bus.dir;
            st     <= ST_LATCH;
            busy_q <= 1'b1;
          end
        end
        ST_LATCH: begin
          work     <= bus.board_in;
          orig     <= bus.board_in;
          line_idx <= 2'd0;
          st       <= ST_SLIDE;
        end
        ST_SLIDE: begin
          work     <= work_slid;
          line_idx <= line_idx + 2'd1;
          if (line_idx == 2'd3)
            st <= (work_slid != orig) ? ST_SPAWN : ST_RELEASE;
        end
        ST_SPAWN: begin
          // board_out and load change together so load is high exactly during COMMIT
          work        <= work_spawn;
          board_out_q <= work_spawn;
          load_q      <= 1'b1;
          st          <= ST_COMMIT;
        end
        ST_COMMIT: begin
          st <= ST_CHECK;
        end
        ST_CHECK: begin
          end_q <= end_next;
          if (end_next != END_PLAY) begin
            st     <= ST_OVER;
            busy_q <= 1'b0;
          end else begin
            st <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (bus.dir == 4'd0) begin
            st     <= ST_IDLE;
            busy_q <= 1'b0;
          end
        end
        ST_OVER: begin
          st <= ST_OVER;
        end
        default: begin
          st     <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer: hand-computed boards, latency, load pulses and end status.
// Latency: n/a.
// Backpressure: n/a.
module tb_move_sequencer;

  localparam logic [3:0] D_UP    = 4'b1000;
  localparam logic [3:0] D_DOWN  = 4'b0100;
  localparam logic [3:0] D_LEFT  = 4'b0010;
  localparam logic [3:0] D_RIGHT = 4'b0001;

  logic clock = 1'b0;
  logic reset;
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   load_cnt = 0;

  always #5 clock = ~clock;

  move_sequencer_if bus();

  move_sequencer #(.WIN_CODE(11), .LFSR_SEED(16'hACE1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always @(posedge clock) cyc++;
  always @(negedge clock) if (bus.load === 1'b1) load_cnt++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    bus.dir = 4'd0;
    tick();
    tick();
    reset   = 1'b0;
  endtask

  function automatic logic [3:0] getc(input logic [63:0] b, input int n);
    return b[63-4*n -: 4];
  endfunction

  // Number of cells where the observed board differs from the expected pre-spawn board
  function automatic int ndiff(input logic [63:0] obs, input logic [63:0] exp);
    int c = 0;
    for (int n = 0; n < 16; n++) if (getc(obs, n) != getc(exp, n)) c++;
    return c;
  endfunction

  // Blank out cells that hold a legal spawn (code 1/2 where the expected board is empty)
  function automatic logic [63:0] strip(input logic [63:0] obs, input logic [63:0] exp);
    logic [63:0] r = obs;
    for (int n = 0; n < 16; n++)
      if (getc(exp, n) == 4'd0 && (getc(obs, n) == 4'd1 || getc(obs, n) == 4'd2))
        r[63-4*n -: 4] = 4'd0;
    return r;
  endfunction

  // Drive one key press, hold it until the FSM settles in RELEASE/OVER, then let go
  task automatic do_move(input logic [63:0] b, input logic [3:0] d,
                         output logic [63:0] res, output int lat, output int loads,
                         output logic [2:0] st_end, output logic bsy);
    int c0 = -1;
    int c1 = -1;
    int l0;
    res  = '0;
    bsy  = 1'b0;
    l0   = load_cnt;
    bus.board_in = b;
    bus.dir      = d;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (c0 < 0 && bus.state == 3'd1) c0 = cyc;
      if (c1 < 0 && bus.load === 1'b1) begin
        c1  = cyc;
        res = bus.board_out;
        bsy = bus.busy;
      end
      if (bus.state == 3'd6 || bus.state == 3'd7) break;
    end
    st_end  = bus.state;
    bus.dir = 4'd0;
    tick();
    tick();
    lat   = c1 - c0;
    loads = load_cnt - l0;
  endtask

  task automatic wait_state(input logic [2:0] s, input string tag);
    for (int i = 0; i < 50 && bus.state != s; i++) tick();
    chk(tag, bus.state, s);
  endtask

  logic [63:0] res;
  logic [63:0] exp;
  int          lat;
  int          loads;
  logic [2:0]  st_end;
  logic        bsy;
  int          l0;

  initial begin
    reset        = 1'b1;
    bus.dir      = 4'd0;
    bus.board_in = '0;
    do_reset();

    // Reset state
    chk("rst_board_out", bus.board_out, 64'd0);
    chk("rst_load",      bus.load, 1'b0);
    chk("rst_busy",      bus.busy, 1'b0);
    chk("rst_endstatus", bus.endstatus, 2'b00);
    chk("rst_state",     bus.state, 3'd0);

    // Row0 [1,1,2,2] left -> [2,3,0,0] plus one spawn
    exp = 64'h2300_0000_0000_0000;
    do_move(64'h1122_0000_0000_0000, D_LEFT, res, lat, loads, st_end, bsy);
    chk("t1_board",   strip(res, exp), exp);
    chk("t1_spawn",   ndiff(res, exp), 1);
    chk("t1_latency", lat, 6);
    chk("t1_loads",   loads, 1);
    chk("t1_busy",    bsy, 1'b1);
    chk("t1_status",  bus.endstatus, 2'b00);
    chk("t1_idle",    bus.state, 3'd0);
    chk("t1_idle_busy", bus.busy, 1'b0);

    // Single-merge rule and saturation, left
    exp = 64'h2200_F000_0000_0000;
    do_move(64'h2110_FF00_0000_0000, D_LEFT, res, lat, loads, st_end, bsy);
    chk("t2_left",       strip(res, exp), exp);
    chk("t2_left_spawn", ndiff(res, exp), 1);

    // [1,1,1,1] right -> [0,0,2,2]
    exp = 64'h0022_0000_0000_0000;
    do_move(64'h1111_0000_0000_0000, D_RIGHT, res, lat, loads, st_end, bsy);
    chk("t2_right",       strip(res, exp), exp);
    chk("t2_right_spawn", ndiff(res, exp), 1);

    // Column0 [1,0,1,0] up -> [2,0,0,0]
    exp = 64'h2000_0000_0000_0000;
    do_move(64'h1000_0000_1000_0000, D_UP, res, lat, loads, st_end, bsy);
    chk("t2_up",       strip(res, exp), exp);
    chk("t2_up_spawn", ndiff(res, exp), 1);

    // Column1 [3,0,0,4] down -> rows2,3 = 3,4
    exp = 64'h0000_0000_0300_0400;
    do_move(64'h0300_0000_0000_0400, D_DOWN, res, lat, loads, st_end, bsy);
    chk("t2_down",       strip(res, exp), exp);
    chk("t2_down_spawn", ndiff(res, exp), 1);

    // Already left-packed with no equal neighbours: no move, no load
    do_move(64'h1230_4000_0000_5600, D_LEFT, res, lat, loads, st_end, bsy);
    chk("t3_loads",   loads, 0);
    chk("t3_release", st_end, 3'd6);
    chk("t3_idle",    bus.state, 3'd0);

    // Reaching 11 wins and locks the FSM
    exp = 64'hB000_0000_0000_0000;
    do_move(64'hAA00_0000_0000_0000, D_LEFT, res, lat, loads, st_end, bsy);
    chk("t4_board",  strip(res, exp), exp);
    chk("t4_over",   st_end, 3'd7);
    chk("t4_status", bus.endstatus, 2'b01);
    chk("t4_busy",   bus.busy, 1'b0);
    l0 = load_cnt;
    for (int p = 0; p < 3; p++) begin
      bus.dir = D_LEFT;
      repeat (3) tick();
      bus.dir = 4'd0;
      repeat (3) tick();
    end
    chk("t4_no_load", load_cnt - l0, 0);
    chk("t4_stuck",   bus.state, 3'd7);

    // Last empty cell fills with no equal neighbours: lose
    do_reset();
    exp = 64'h0343_3434_4343_3434;
    do_move(64'h3430_3434_4343_3434, D_RIGHT, res, lat, loads, st_end, bsy);
    chk("t5_board",  strip(res, exp), exp);
    chk("t5_spawn",  ndiff(res, exp), 1);
    chk("t5_status", bus.endstatus, 2'b10);
    chk("t5_over",   st_end, 3'd7);

    // Held key gives exactly one move
    do_reset();
    bus.board_in = 64'h1100_0000_0000_0000;
    l0 = load_cnt;
    bus.dir = D_LEFT;
    repeat (100) tick();
    bus.dir = 4'd0;
    repeat (3) tick();
    chk("t6_one_load", load_cnt - l0, 1);
    chk("t6_idle",     bus.state, 3'd0);

    // Reset during SLIDE abandons the move
    l0 = load_cnt;
    bus.dir = D_LEFT;
    wait_state(3'd2, "t6_reach_slide");
    reset   = 1'b1;
    bus.dir = 4'd0;
    tick();
    chk("t6_rst_board", bus.board_out, 64'd0);
    chk("t6_rst_state", bus.state, 3'd0);
    chk("t6_rst_load",  bus.load, 1'b0);
    reset = 1'b0;
    repeat (20) tick();
    chk("t6_abandon_load", load_cnt - l0, 0);
    chk("t6_abandon_idle", bus.state, 3'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
